// File: rtl/decode_stage_hz.sv
// decode_stage_hz: ARM decode stage with a 15-entry register file (r15 reads
// PCPlus8D) and write-through bypass, the immediate extender, and the D->E
// pipeline register with flush/stall/bubble control and load-use detection.
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   InstrD, ValidD      - instruction in Decode and its valid flag
//   PCPlus8D            - value returned for reads of r15
//   CtrlD               - opaque control bundle carried to E
//   RegSrcD, ImmSrcD    - read-address and immediate-format selects
//   StallE, FlushE      - E register hold / bubble requests
//   RegWriteW, WA3W,
//   ResultW             - writeback port
//   RD1E..RD3E, ExtImmE,
//   WA3E, RA1E, RA2E,
//   CondE, CtrlE, ValidE - registered E outputs
//   LdUseStall          - combinational load-use hazard, holds F and D
module decode_stage_hz #(
  parameter int DATA_W       = 32,
  parameter int CTRL_W       = 16,
  parameter int REGWRITE_BIT = 0,
  parameter int MEMTOREG_BIT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       InstrD,
  input  logic              ValidD,
  input  logic [DATA_W-1:0] PCPlus8D,
  input  logic [CTRL_W-1:0] CtrlD,
  input  logic [1:0]        RegSrcD,
  input  logic [1:0]        ImmSrcD,
  input  logic              StallE,
  input  logic              FlushE,
  input  logic              RegWriteW,
  input  logic [3:0]        WA3W,
  input  logic [DATA_W-1:0] ResultW,
  output logic [DATA_W-1:0] RD1E,
  output logic [DATA_W-1:0] RD2E,
  output logic [DATA_W-1:0] RD3E,
  output logic [DATA_W-1:0] ExtImmE,
  output logic [3:0]        WA3E,
  output logic [3:0]        RA1E,
  output logic [3:0]        RA2E,
  output logic [3:0]        CondE,
  output logic [CTRL_W-1:0] CtrlE,
  output logic              ValidE,
  output logic              LdUseStall
);

  // Register file
  logic [DATA_W-1:0] rf_q [15];
  logic [DATA_W-1:0] rf_d [15];
  logic              wr_en;

  assign wr_en = RegWriteW && (WA3W != 4'd15);

  always_comb begin
    rf_d = rf_q;
    if (wr_en) rf_d[WA3W] = ResultW;
  end

  always_ff @(posedge clk) begin
    if (reset) rf_q <= '{default: '0};
    else       rf_q <= rf_d;
  end

  // Read ports: 0 = RA1, 1 = RA2, 2 = Instr[15:12]
  logic [3:0]        ra_d [3];
  logic [DATA_W-1:0] rd_d [3];

  always_comb begin
    ra_d[0] = RegSrcD[0] ? 4'd15 : InstrD[19:16];
    ra_d[1] = RegSrcD[1] ? InstrD[15:12] : InstrD[3:0];
    ra_d[2] = InstrD[15:12];
  end

  always_comb begin
    for (int unsigned i = 0; i < 3; i++) begin
      if (ra_d[i] == 4'd15)                rd_d[i] = PCPlus8D;
      else if (wr_en && WA3W == ra_d[i])   rd_d[i] = ResultW;
      else                                 rd_d[i] = rf_q[ra_d[i]];
    end
  end

  // Immediate extension
  logic [63:0]       rot_dbl;
  logic [31:0]       imm_rot;
  logic [DATA_W-1:0] ext_imm_d;

  always_comb begin
    rot_dbl = {24'd0, InstrD[7:0], 24'd0, InstrD[7:0]} >> {InstrD[11:8], 1'b0};
    imm_rot = rot_dbl[31:0];
    case (ImmSrcD)
      2'b00:   ext_imm_d = DATA_W'(imm_rot);
      2'b01:   ext_imm_d = DATA_W'(InstrD[11:0]);
      2'b10:   ext_imm_d = DATA_W'($signed({InstrD[23:0], 2'b00}));
      default: ext_imm_d = '0;
    endcase
  end

  // E register
  logic [DATA_W-1:0] rd1_e_q, rd1_e_d, rd2_e_q, rd2_e_d, rd3_e_q, rd3_e_d;
  logic [DATA_W-1:0] imm_e_q, imm_e_d;
  logic [3:0]        wa3_e_q, wa3_e_d, ra1_e_q, ra1_e_d, ra2_e_q, ra2_e_d;
  logic [3:0]        cond_e_q, cond_e_d;
  logic [CTRL_W-1:0] ctrl_e_q, ctrl_e_d;
  logic              valid_e_q, valid_e_d;
  logic              ld_use;

  assign ld_use = valid_e_q && ctrl_e_q[MEMTOREG_BIT] && ctrl_e_q[REGWRITE_BIT] &&
                  (wa3_e_q == ra_d[0] || wa3_e_q == ra_d[1]) && ValidD;

  // Flush and bubble both load D's datapath fields (don't-care in a bubble),
  // so the register only holds on a stall without flush.
  always_comb begin
    rd1_e_d   = rd1_e_q;
    rd2_e_d   = rd2_e_q;
    rd3_e_d   = rd3_e_q;
    imm_e_d   = imm_e_q;
    wa3_e_d   = wa3_e_q;
    ra1_e_d   = ra1_e_q;
    ra2_e_d   = ra2_e_q;
    cond_e_d  = cond_e_q;
    ctrl_e_d  = ctrl_e_q;
    valid_e_d = valid_e_q;
    if (FlushE || !StallE) begin
      rd1_e_d   = rd_d[0];
      rd2_e_d   = rd_d[1];
      rd3_e_d   = rd_d[2];
      imm_e_d   = ext_imm_d;
      wa3_e_d   = InstrD[15:12];
      ra1_e_d   = ra_d[0];
      ra2_e_d   = ra_d[1];
      cond_e_d  = InstrD[31:28];
      valid_e_d = !FlushE && !ld_use && ValidD;
      ctrl_e_d  = valid_e_d ? CtrlD : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd1_e_q   <= '0;
      rd2_e_q   <= '0;
      rd3_e_q   <= '0;
      imm_e_q   <= '0;
      wa3_e_q   <= '0;
      ra1_e_q   <= '0;
      ra2_e_q   <= '0;
      cond_e_q  <= '0;
      ctrl_e_q  <= '0;
      valid_e_q <= 1'b0;
    end else begin
      rd1_e_q   <= rd1_e_d;
      rd2_e_q   <= rd2_e_d;
      rd3_e_q   <= rd3_e_d;
      imm_e_q   <= imm_e_d;
      wa3_e_q   <= wa3_e_d;
      ra1_e_q   <= ra1_e_d;
      ra2_e_q   <= ra2_e_d;
      cond_e_q  <= cond_e_d;
      ctrl_e_q  <= ctrl_e_d;
      valid_e_q <= valid_e_d;
    end
  end

  assign RD1E       = rd1_e_q;
  assign RD2E       = rd2_e_q;
  assign RD3E       = rd3_e_q;
  assign ExtImmE    = imm_e_q;
  assign WA3E       = wa3_e_q;
  assign RA1E       = ra1_e_q;
  assign RA2E       = ra2_e_q;
  assign CondE      = cond_e_q;
  assign CtrlE      = ctrl_e_q;
  assign ValidE     = valid_e_q;
  assign LdUseStall = ld_use;

endmodule

// File: tb/tb_decode_stage_hz.sv
module tb_decode_stage_hz;

  logic        clk;
  logic        reset;
  logic [31:0] InstrD;
  logic        ValidD;
  logic [31:0] PCPlus8D;
  logic [15:0] CtrlD;
  logic [1:0]  RegSrcD;
  logic [1:0]  ImmSrcD;
  logic        StallE;
  logic        FlushE;
  logic        RegWriteW;
  logic [3:0]  WA3W;
  logic [31:0] ResultW;
  logic [31:0] RD1E, RD2E, RD3E, ExtImmE;
  logic [3:0]  WA3E, RA1E, RA2E, CondE;
  logic [15:0] CtrlE;
  logic        ValidE;
  logic        LdUseStall;

  decode_stage_hz #(
    .DATA_W(32), .CTRL_W(16), .REGWRITE_BIT(0), .MEMTOREG_BIT(1)
  ) dut (
    .clk(clk), .reset(reset), .InstrD(InstrD), .ValidD(ValidD),
    .PCPlus8D(PCPlus8D), .CtrlD(CtrlD), .RegSrcD(RegSrcD), .ImmSrcD(ImmSrcD),
    .StallE(StallE), .FlushE(FlushE), .RegWriteW(RegWriteW), .WA3W(WA3W),
    .ResultW(ResultW), .RD1E(RD1E), .RD2E(RD2E), .RD3E(RD3E),
    .ExtImmE(ExtImmE), .WA3E(WA3E), .RA1E(RA1E), .RA2E(RA2E),
    .CondE(CondE), .CtrlE(CtrlE), .ValidE(ValidE), .LdUseStall(LdUseStall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  bit chk_on = 1'b0;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model of the E register contents and the register file
  typedef struct {
    logic [31:0] rd1, rd2, rd3, imm;
    logic [3:0]  wa3, ra1, ra2, cond;
    logic [15:0] ctrl;
    bit          valid;
    bit          known;   // datapath fields are defined (not a bubble)
  } e_t;

  e_t          me;
  logic [31:0] mrf [15];

  function automatic logic [3:0] m_ra1();
    return RegSrcD[0] ? 4'd15 : InstrD[19:16];
  endfunction

  function automatic logic [3:0] m_ra2();
    return RegSrcD[1] ? InstrD[15:12] : InstrD[3:0];
  endfunction

  function automatic logic [31:0] mread(input logic [3:0] a);
    if (a == 4'd15) return PCPlus8D;
    if (RegWriteW && WA3W == a) return ResultW;
    return mrf[a];
  endfunction

  function automatic logic [31:0] mimm(input logic [31:0] ins, input logic [1:0] src);
    logic [31:0] v;
    int          s;
    int          n;
    case (src)
      2'd0: begin
        v = {24'd0, ins[7:0]};
        n = 2 * int'(ins[11:8]);
        for (int k = 0; k < n; k++) v = {v[0], v[31:1]};
        return v;
      end
      2'd1: return {20'd0, ins[11:0]};
      2'd2: begin
        s = int'(ins[23:0]);
        if (s >= (1 << 23)) s = s - (1 << 24);
        return 32'(s * 4);
      end
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit mlu();
    return me.valid && me.ctrl[1] && me.ctrl[0] &&
           (me.wa3 == m_ra1() || me.wa3 == m_ra2()) && ValidD;
  endfunction

  always @(posedge clk) begin
    e_t n;
    n = me;
    if (reset) begin
      n = '{rd1: 0, rd2: 0, rd3: 0, imm: 0, wa3: 0, ra1: 0, ra2: 0, cond: 0,
            ctrl: 0, valid: 0, known: 1};
      for (int i = 0; i < 15; i++) mrf[i] <= 32'd0;
    end else begin
      if (RegWriteW && WA3W != 4'd15) mrf[WA3W] <= ResultW;
      if (FlushE) begin
        n.valid = 0; n.ctrl = 0; n.known = 0;
      end else if (StallE) begin
        n = me;
      end else if (mlu() || !ValidD) begin
        n.valid = 0; n.ctrl = 0; n.known = 0;
      end else begin
        n.rd1   = mread(m_ra1());
        n.rd2   = mread(m_ra2());
        n.rd3   = mread(InstrD[15:12]);
        n.imm   = mimm(InstrD, ImmSrcD);
        n.wa3   = InstrD[15:12];
        n.ra1   = m_ra1();
        n.ra2   = m_ra2();
        n.cond  = InstrD[31:28];
        n.ctrl  = CtrlD;
        n.valid = 1;
        n.known = 1;
      end
    end
    me <= n;
  end

  // Per-cycle compare against the model
  always @(negedge clk) begin
    if (chk_on) begin
      cmp("ValidE", 64'(ValidE), 64'(me.valid));
      cmp("CtrlE", 64'(CtrlE), 64'(me.ctrl));
      cmp("LdUseStall", 64'(LdUseStall), 64'(mlu()));
      if (me.known) begin
        cmp("RD1E", 64'(RD1E), 64'(me.rd1));
        cmp("RD2E", 64'(RD2E), 64'(me.rd2));
        cmp("RD3E", 64'(RD3E), 64'(me.rd3));
        cmp("ExtImmE", 64'(ExtImmE), 64'(me.imm));
        cmp("WA3E", 64'(WA3E), 64'(me.wa3));
        cmp("RA1E", 64'(RA1E), 64'(me.ra1));
        cmp("RA2E", 64'(RA2E), 64'(me.ra2));
        cmp("CondE", 64'(CondE), 64'(me.cond));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  initial begin
    reset = 1; InstrD = 0; ValidD = 0; PCPlus8D = 0; CtrlD = 0; RegSrcD = 0;
    ImmSrcD = 0; StallE = 0; FlushE = 0; RegWriteW = 0; WA3W = 0; ResultW = 0;
    cyc();
    chk_on = 1;
    cyc();
    cmp("lit_reset_ValidE", 64'(ValidE), 64'd0);
    cmp("lit_reset_CtrlE", 64'(CtrlE), 64'd0);
    cmp("lit_reset_RD1E", 64'(RD1E), 64'd0);
    cmp("lit_reset_ExtImmE", 64'(ExtImmE), 64'd0);
    cmp("lit_reset_WA3E", 64'(WA3E), 64'd0);
    reset = 0;

    // read r3 after reset
    InstrD = 32'hE003_0000; CtrlD = 16'h0004; ValidD = 1; ImmSrcD = 2'd3;
    cyc();
    cmp("lit_r3_RD1E", 64'(RD1E), 64'd0);
    cmp("lit_r3_ValidE", 64'(ValidE), 64'd1);
    cmp("lit_r3_CtrlE", 64'(CtrlE), 64'h4);

    // writeback bypass to r5
    InstrD = 32'hE005_0000; RegWriteW = 1; WA3W = 4'd5; ResultW = 32'hDEADBEEF;
    cyc();
    cmp("lit_bypass_RD1E", 64'(RD1E), 64'hDEADBEEF);

    // write to r15 ignored, r15 reads PC+8
    WA3W = 4'd15; ResultW = 32'h1234; RegSrcD = 2'b01; PCPlus8D = 32'h108;
    cyc();
    cmp("lit_r15_RD1E", 64'(RD1E), 64'h108);
    RegWriteW = 0; RegSrcD = 2'b00; InstrD = 32'hE00F_F005;
    cyc();
    cmp("lit_r15b_RD1E", 64'(RD1E), 64'h108);
    cmp("lit_r5_RD2E", 64'(RD2E), 64'hDEADBEEF);
    cmp("lit_r15_RD3E", 64'(RD3E), 64'h108);

    // immediate formats
    InstrD = 32'hE000_04FF; ImmSrcD = 2'd0;
    cyc();
    cmp("lit_imm_rot", 64'(ExtImmE), 64'hFF000000);
    InstrD = 32'hEAFF_FFFE; ImmSrcD = 2'd2;
    cyc();
    cmp("lit_imm_branch", 64'(ExtImmE), 64'hFFFFFFF8);
    InstrD = 32'hE000_0ABC; ImmSrcD = 2'd1;
    cyc();
    cmp("lit_imm_zext12", 64'(ExtImmE), 64'hABC);

    // load-use: load r2 then add reading r2
    InstrD = 32'hE597_2000; CtrlD = 16'h0003;
    cyc();
    InstrD = 32'hE082_4003; CtrlD = 16'h0001;
    #1;
    cmp("lit_lduse_assert", 64'(LdUseStall), 64'd1);
    cyc();
    cmp("lit_lduse_bubble_ValidE", 64'(ValidE), 64'd0);
    cmp("lit_lduse_bubble_CtrlE", 64'(CtrlE), 64'd0);
    cmp("lit_lduse_clear", 64'(LdUseStall), 64'd0);
    cyc();
    cmp("lit_lduse_add_ValidE", 64'(ValidE), 64'd1);
    cmp("lit_lduse_add_CtrlE", 64'(CtrlE), 64'h1);
    cmp("lit_lduse_add_WA3E", 64'(WA3E), 64'h4);

    // stall holds E for 3 cycles, then flush wins over stall
    InstrD = 32'hA031_9321; CtrlD = 16'h0055; ImmSrcD = 2'd1;
    cyc();
    StallE = 1;
    for (int i = 0; i < 3; i++) begin
      InstrD = $urandom; CtrlD = 16'($urandom); ImmSrcD = 2'($urandom_range(0, 3));
      cyc();
      cmp("lit_stall_CondE", 64'(CondE), 64'hA);
      cmp("lit_stall_WA3E", 64'(WA3E), 64'h9);
      cmp("lit_stall_ExtImmE", 64'(ExtImmE), 64'h321);
      cmp("lit_stall_CtrlE", 64'(CtrlE), 64'h55);
      cmp("lit_stall_ValidE", 64'(ValidE), 64'd1);
    end
    FlushE = 1;
    cyc();
    cmp("lit_flush_ValidE", 64'(ValidE), 64'd0);
    cmp("lit_flush_CtrlE", 64'(CtrlE), 64'd0);
    FlushE = 0; StallE = 0;

    // random stream
    for (int i = 0; i < 1000; i++) begin
      reset = ($urandom_range(0, 99) == 0);
      // usually keep D held while a hazard is flagged, as upstream would
      if (!(mlu() && $urandom_range(0, 3) != 0)) begin
        ValidD = ($urandom_range(0, 9) != 0);
        InstrD = $urandom;
        if ($urandom_range(0, 1) == 1) begin
          InstrD[19:16] = 4'($urandom_range(0, 3));
          InstrD[15:12] = 4'($urandom_range(0, 3));
          InstrD[3:0]   = 4'($urandom_range(0, 3));
        end
        CtrlD   = 16'($urandom);
        RegSrcD = 2'($urandom_range(0, 3));
        ImmSrcD = 2'($urandom_range(0, 3));
      end
      PCPlus8D  = $urandom;
      StallE    = ($urandom_range(0, 6) == 0);
      FlushE    = ($urandom_range(0, 11) == 0);
      RegWriteW = ($urandom_range(0, 1) == 1);
      WA3W      = 4'($urandom_range(0, 15));
      ResultW   = $urandom;
      cyc();
    end

    reset = 0; StallE = 0; FlushE = 0; RegWriteW = 0;
    cyc();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
